// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-stage engine: FSM encoding, default sizes
// and the wait-counter width helper.
package mem_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } mau_state_t;

  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 12;
  localparam int RD_W_DEF    = 5;
  localparam int TIMEOUT_DEF = 15;

  // Counter only needs to reach TIMEOUT-1, so ceil(log2(TIMEOUT)) bits suffice.
  function automatic int cnt_width(input int timeout);
    return (timeout > 2) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/acknowledge bus between the memory-stage engine and the data memory.
interface mem_access_unit_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  // Handshake: the master raises mem_req with mem_we/mem_addr/mem_wdata and holds all of
  // them stable until the slave answers with a single-cycle mem_ack (mem_rdata valid only
  // in that cycle) or the master aborts; a new request always starts after req was low.
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit_wait_counter.sv
// Saturating wait counter: cleared while idle, counts while waiting, flags the last
// permitted cycle of an outstanding request.
module wait_counter
  import mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_expire = (r_cnt == LAST);

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage engine: issues loads/stores from the X/M latch, stalls upstream while the
// memory is busy, aborts hung requests and produces the registered M/W write-back fields.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int RD_W    = RD_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               xm_valid,
  input  logic [DATA_W-1:0]  xm_o,
  input  logic [DATA_W-1:0]  xm_d,
  input  logic               xm_wmem,
  input  logic               xm_lw,
  input  logic               xm_wreg,
  input  logic [RD_W-1:0]    xm_rd,
  output logic               stall,
  mem_access_unit_if.master  mem,
  output logic               mw_valid,
  output logic [DATA_W-1:0]  mw_data,
  output logic [RD_W-1:0]    mw_rd,
  output logic               mw_wreg,
  output logic               mem_err,
  output mau_state_t         dbg_state
);

  mau_state_t        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic [RD_W-1:0]   r_rd;
  logic              r_wreg;
  logic              r_mw_valid;
  logic [DATA_W-1:0] r_mw_data;
  logic [RD_W-1:0]   r_mw_rd;
  logic              r_mw_wreg;
  logic              r_err;

  logic w_mem_op;
  logic w_expire;
  logic w_in_wait;
  logic w_unused_hi;

  assign w_mem_op    = xm_valid & (xm_wmem | xm_lw);
  assign w_in_wait   = (r_state == S_WAIT);
  assign w_unused_hi = &{1'b0, xm_o[DATA_W-1:ADDR_W]};

  wait_counter #(.TIMEOUT(TIMEOUT)) u_wait_counter (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (!w_in_wait),
    .i_enable (w_in_wait),
    .o_expire (w_expire)
  );

  // Stall must drop in the completing/aborting cycle so the next op is latched on time.
  always_comb begin
    stall = 1'b0;
    if (w_in_wait) stall = !(mem.mem_ack || w_expire);
    else           stall = w_mem_op;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_rd       <= '0;
      r_wreg     <= 1'b0;
      r_mw_valid <= 1'b0;
      r_mw_data  <= '0;
      r_mw_rd    <= '0;
      r_mw_wreg  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mem_op) begin
            r_addr     <= xm_o[ADDR_W-1:0];
            r_wdata    <= xm_d;
            r_we       <= xm_wmem;
            r_rd       <= xm_rd;
            r_wreg     <= xm_wreg;
            r_mw_valid <= 1'b0;
            r_mw_wreg  <= 1'b0;
            r_state    <= S_WAIT;
          end else begin
            r_mw_valid <= xm_valid;
            r_mw_data  <= xm_o;
            r_mw_rd    <= xm_rd;
            r_mw_wreg  <= xm_valid & xm_wreg & (xm_rd != '0);
          end
        end
        S_WAIT: begin
          // A late ack in the expiry cycle still completes the access normally.
          if (mem.mem_ack) begin
            r_mw_valid <= 1'b1;
            r_mw_rd    <= r_rd;
            r_mw_data  <= r_we ? {{(DATA_W-ADDR_W){1'b0}}, r_addr} : mem.mem_rdata;
            r_mw_wreg  <= !r_we & r_wreg & (r_rd != '0);
            r_state    <= S_IDLE;
          end else if (w_expire) begin
            r_mw_valid <= 1'b1;
            r_mw_rd    <= r_rd;
            r_mw_data  <= '0;
            r_mw_wreg  <= 1'b0;
            r_err      <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem.mem_req   = w_in_wait;
  assign mem.mem_we    = r_we;
  assign mem.mem_addr  = r_addr;
  assign mem.mem_wdata = r_wdata;

  assign mw_valid  = r_mw_valid;
  assign mw_data   = r_mw_data;
  assign mw_rd     = r_mw_rd;
  assign mw_wreg   = r_mw_wreg;
  assign mem_err   = r_err;
  assign dbg_state = r_state;

endmodule
